// File: rtl/delay_pkg.sv
// delay_pkg: shared constants and helpers for the delay_line slice.
//   DEPTH_MAX      largest supported line depth
//   REG_WIDTH_DEF  default lane element width
//   VECTOR_DEF     default number of lanes per operand
//   clamp_dly()    maps a requested delay onto the legal range 1..depth
package delay_pkg;

    localparam int unsigned DEPTH_MAX     = 64;
    localparam int unsigned REG_WIDTH_DEF = 16;
    localparam int unsigned VECTOR_DEF    = 2;

    function automatic int unsigned clamp_dly(input int unsigned sel, input int unsigned depth);
        if (sel == 0) begin
            return 1;
        end else if (sel > depth) begin
            return depth;
        end else begin
            return sel;
        end
    endfunction

endpackage

// File: rtl/delay_stage.sv
// delay_stage: one element of the delay line (valid bit plus A/B lane vectors).
//   clk      clock, rising edge
//   en_i     shift enable; stage holds when low
//   clr_i    synchronous clear of valid and data, wins over en_i
//   valid_i  incoming valid bit
//   a_i/b_i  incoming lane vectors
//   valid_o  stored valid bit
//   a_o/b_o  stored lane vectors
module delay_stage
    import delay_pkg::*;
#(
    parameter int unsigned REG_WIDTH = REG_WIDTH_DEF,
    parameter int unsigned VECTOR    = VECTOR_DEF
) (
    input  logic                 clk,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 valid_i,
    input  logic [REG_WIDTH-1:0] a_i [VECTOR],
    input  logic [REG_WIDTH-1:0] b_i [VECTOR],
    output logic                 valid_o,
    output logic [REG_WIDTH-1:0] a_o [VECTOR],
    output logic [REG_WIDTH-1:0] b_o [VECTOR]
);

    logic                 valid_q, valid_d;
    logic [REG_WIDTH-1:0] a_q [VECTOR];
    logic [REG_WIDTH-1:0] a_d [VECTOR];
    logic [REG_WIDTH-1:0] b_q [VECTOR];
    logic [REG_WIDTH-1:0] b_d [VECTOR];

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        if (clr_i) begin
            valid_d = 1'b0;
            a_d     = '{default: '0};
            b_d     = '{default: '0};
        end else if (en_i) begin
            valid_d = valid_i;
            // Invalid slots carry zero data so the output needs no extra masking downstream.
            for (int l = 0; l < VECTOR; l++) begin
                a_d[l] = valid_i ? a_i[l] : '0;
                b_d[l] = valid_i ? b_i[l] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        a_q     <= a_d;
        b_q     <= b_d;
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;

endmodule

// File: rtl/delay_line.sv
// delay_line: DEPTH-stage operand delay line with a selectable output tap.
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   a_n_1/b_n_1 carry a sample this cycle
//   a_n_1      operand A sample (VECTOR lanes)
//   b_n_1      operand B sample (VECTOR lanes)
//   dly_sel    requested delay; 0 acts as 1, values above DEPTH act as DEPTH
//   stall      freezes stages, tap selection and prime counter
//   flush      drops every in-flight sample
//   a_n, b_n   delayed operands, zero when out_valid is low
//   out_valid  tap stage holds a valid sample
//   primed     the line has shifted at least eff_dly times since reset/flush
module delay_line
    import delay_pkg::*;
#(
    parameter int unsigned REG_WIDTH = REG_WIDTH_DEF,
    parameter int unsigned VECTOR    = VECTOR_DEF,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [REG_WIDTH-1:0]       a_n_1 [VECTOR],
    input  logic [REG_WIDTH-1:0]       b_n_1 [VECTOR],
    input  logic [$clog2(DEPTH+1)-1:0] dly_sel,
    input  logic                       stall,
    input  logic                       flush,
    output logic [REG_WIDTH-1:0]       a_n [VECTOR],
    output logic [REG_WIDTH-1:0]       b_n [VECTOR],
    output logic                       out_valid,
    output logic                       primed
);

    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    logic                 clr;
    logic                 shift_en;
    logic                 st_v [DEPTH];
    logic [REG_WIDTH-1:0] st_a [DEPTH][VECTOR];
    logic [REG_WIDTH-1:0] st_b [DEPTH][VECTOR];

    logic [SEL_W-1:0]     eff_q, eff_d;
    logic [SEL_W-1:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]     tap_idx;
    logic                 tap_v;
    logic [REG_WIDTH-1:0] tap_a [VECTOR];
    logic [REG_WIDTH-1:0] tap_b [VECTOR];

    assign clr      = rst | flush;
    assign shift_en = ~stall;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            delay_stage #(
                .REG_WIDTH (REG_WIDTH),
                .VECTOR    (VECTOR)
            ) u_stage (
                .clk     (clk),
                .en_i    (shift_en),
                .clr_i   (clr),
                .valid_i (in_valid),
                .a_i     (a_n_1),
                .b_i     (b_n_1),
                .valid_o (st_v[i]),
                .a_o     (st_a[i]),
                .b_o     (st_b[i])
            );
        end else begin : g_body
            delay_stage #(
                .REG_WIDTH (REG_WIDTH),
                .VECTOR    (VECTOR)
            ) u_stage (
                .clk     (clk),
                .en_i    (shift_en),
                .clr_i   (clr),
                .valid_i (st_v[i-1]),
                .a_i     (st_a[i-1]),
                .b_i     (st_b[i-1]),
                .valid_o (st_v[i]),
                .a_o     (st_a[i]),
                .b_o     (st_b[i])
            );
        end
    end

    // The tap selection is registered so the outputs depend only on flops;
    // a new dly_sel moves the tap from the next edge, and a stall freezes it.
    always_comb begin
        eff_d = eff_q;
        if (clr || shift_en) begin
            eff_d = SEL_W'(clamp_dly(32'(dly_sel), DEPTH));
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (shift_en && (cnt_q != SEL_W'(DEPTH))) begin
            cnt_d = cnt_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        eff_q <= eff_d;
        cnt_q <= cnt_d;
    end

    assign primed  = (cnt_q >= eff_q);
    assign tap_idx = eff_q - SEL_W'(1);

    always_comb begin
        tap_v = 1'b0;
        tap_a = '{default: '0};
        tap_b = '{default: '0};
        for (int i = 0; i < DEPTH; i++) begin
            if (SEL_W'(i) == tap_idx) begin
                tap_v = st_v[i];
                tap_a = st_a[i];
                tap_b = st_b[i];
            end
        end
    end

    assign out_valid = tap_v;

    always_comb begin
        for (int l = 0; l < VECTOR; l++) begin
            a_n[l] = tap_v ? tap_a[l] : '0;
            b_n[l] = tap_v ? tap_b[l] : '0;
        end
    end

endmodule

// File: tb/tb_delay_line.sv
// tb_delay_line: scoreboard bench for delay_line (DEPTH=8, 2 lanes of 16 bits).
module tb_delay_line;

    localparam int RW    = 16;
    localparam int VEC   = 2;
    localparam int DEPTH = 8;
    localparam int SW    = $clog2(DEPTH + 1);

    typedef struct {
        int val;
        int due;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [RW-1:0] a_n_1 [VEC];
    logic [RW-1:0] b_n_1 [VEC];
    logic [SW-1:0] dly_sel;
    logic          stall;
    logic          flush;
    logic [RW-1:0] a_n [VEC];
    logic [RW-1:0] b_n [VEC];
    logic          out_valid;
    logic          primed;

    int   errors = 0;
    int   checks = 0;
    int   sel_r  = 3;

    exp_t q[$];
    int   shift_cnt = 0;
    int   pcnt      = 0;
    int   cur_eff   = 1;
    bit   clr_edge  = 0;
    bit   shifted   = 0;
    bit   started   = 0;

    delay_line #(
        .REG_WIDTH (RW),
        .VECTOR    (VEC),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a_n_1     (a_n_1),
        .b_n_1     (b_n_1),
        .dly_sel   (dly_sel),
        .stall     (stall),
        .flush     (flush),
        .a_n       (a_n),
        .b_n       (b_n),
        .out_valid (out_valid),
        .primed    (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] lane_a(input int v, input int l);
        return (l == 0) ? RW'(v) : RW'(v + 100);
    endfunction

    function automatic logic [RW-1:0] lane_b(input int v, input int l);
        return (l == 0) ? (RW'(v) ^ 16'h5555) : ~RW'(v);
    endfunction

    function automatic logic [63:0] pack_exp(input int v);
        return {lane_a(v, 1), lane_a(v, 0), lane_b(v, 1), lane_b(v, 0)};
    endfunction

    function automatic int clamp(input int d);
        if (d == 0) return 1;
        if (d > DEPTH) return DEPTH;
        return d;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input int val, input bit st = 0, input bit fl = 0, input bit r = 0);
        @(negedge clk);
        in_valid = v;
        for (int l = 0; l < VEC; l++) begin
            a_n_1[l] = lane_a(val, l);
            b_n_1[l] = lane_b(val, l);
        end
        stall   = st;
        flush   = fl;
        rst     = r;
        dly_sel = SW'(sel_r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 9999);
    endtask

    // Stimulus tracker: at each edge, record what the DUT accepted and when it is due.
    initial begin
        int e;
        forever begin
            @(posedge clk);
            e       = clamp(int'(dly_sel));
            started = 1;
            if (rst || flush) begin
                q.delete();
                pcnt     = 0;
                cur_eff  = e;
                clr_edge = 1;
                shifted  = 0;
            end else if (stall) begin
                clr_edge = 0;
                shifted  = 0;
            end else begin
                shift_cnt++;
                clr_edge = 0;
                shifted  = 1;
                cur_eff  = e;
                if (pcnt < DEPTH) pcnt++;
                if (in_valid) q.push_back('{val: int'(a_n_1[0]), due: shift_cnt + e - 1});
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard between edges.
    initial begin
        logic [63:0] act;
        logic [63:0] last_act;
        logic        last_v;
        exp_t        ex;
        last_act = '0;
        last_v   = 1'b0;
        forever begin
            @(negedge clk);
            if (started) begin
                act = {a_n[1], a_n[0], b_n[1], b_n[0]};
                chk(primed == (pcnt >= cur_eff), "primed", 64'(primed), 64'(pcnt >= cur_eff));
                if (clr_edge) begin
                    chk(out_valid == 1'b0, "clear_valid", 64'(out_valid), 64'd0);
                    chk(act == '0, "clear_data", act, 64'd0);
                end else if (!shifted) begin
                    chk(out_valid == last_v, "stall_hold_valid", 64'(out_valid), 64'(last_v));
                    chk(act == last_act, "stall_hold_data", act, last_act);
                end else if (out_valid) begin
                    chk(q.size() != 0, "unexpected_valid", act, 64'd0);
                    if (q.size() != 0) begin
                        ex = q.pop_front();
                        chk(ex.due == shift_cnt, "latency", 64'(shift_cnt), 64'(ex.due));
                        chk(act == pack_exp(ex.val), "data", act, pack_exp(ex.val));
                    end
                end else begin
                    chk(act == '0, "idle_zero", act, 64'd0);
                    if (q.size() != 0) begin
                        chk(q[0].due > shift_cnt, "missing_sample", 64'(shift_cnt), 64'(q[0].due));
                        if (q[0].due <= shift_cnt) ex = q.pop_front();
                    end
                end
                last_v   = out_valid;
                last_act = act;
            end
        end
    end

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        dly_sel  = SW'(3);
        for (int l = 0; l < VEC; l++) begin
            a_n_1[l] = '0;
            b_n_1[l] = '0;
        end

        sel_r = 3;
        repeat (3) drive(0, 0, 0, 0, 1);

        // dly 3, continuous stream 1..10
        for (int v = 1; v <= 10; v++) drive(1, v);
        idle(10);

        // dly 4, stall for two cycles mid-stream (stalled inputs must be dropped)
        sel_r = 4;
        drive(0, 0, 0, 1);
        for (int v = 1; v <= 4; v++) drive(1, v);
        drive(1, 99, 1);
        drive(1, 98, 1);
        for (int v = 5; v <= 8; v++) drive(1, v);
        idle(10);

        // dly 5, three in flight then flush, then a fresh sample
        sel_r = 5;
        drive(0, 0, 0, 1);
        drive(1, 1);
        drive(1, 2);
        drive(1, 3);
        drive(1, 77, 0, 1);
        idle(5);
        drive(1, 50);
        idle(7);

        // dly 0 clamps to 1
        sel_r = 0;
        drive(0, 0, 0, 1);
        drive(1, 11);
        drive(1, 12);
        idle(3);

        // dly DEPTH+3 clamps to DEPTH
        sel_r = DEPTH + 3;
        drive(0, 0, 0, 1);
        drive(1, 21);
        idle(3);
        drive(1, 22);
        idle(10);

        // rst, flush, stall and in_valid together, then reset mid-stream
        sel_r = 3;
        drive(0, 0, 0, 1);
        drive(1, 5);
        drive(1, 6);
        drive(1, 33, 1, 1, 1);
        drive(1, 7);
        drive(1, 8);
        drive(1, 40, 0, 0, 1);
        drive(1, 41);
        drive(1, 42);
        idle(6);

        // random valid/stall stream at dly 6
        sel_r = 6;
        drive(0, 0, 0, 1);
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 1000 + i, ($urandom_range(0, 3) == 0));
        end
        idle(12);

        chk(q.size() == 0, "drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
